// File: rtl/lam_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store access manager.
package lam_pkg;

   // funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic LAM_STORE = 1'b1;
   localparam logic LAM_LOAD  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_WB   = 2'd2,
      ST_ERR  = 2'd3
   } lam_state_e;

   // Legal funct3 for the given direction
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store == LAM_STORE)
         return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      else
         return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // funct3[1:0] carries the access size for both loads and stores
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lam_align.sv
// Combinational byte-lane steering for stores and extract/extend for loads.
module lam_align
   import lam_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] ldata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store data replication across lanes and byte-enable generation
   always_comb begin
      wdata_o = sdata_i;
      wstrb_o = 4'b0000;
      case (funct3_i)
         F3_SB: begin
            wdata_o = {4{sdata_i[7:0]}};
            wstrb_o = 4'b0001 << addr_lo_i;
         end
         F3_SH: begin
            wdata_o = {2{sdata_i[15:0]}};
            wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         end
         F3_SW: begin
            wdata_o = sdata_i;
            wstrb_o = 4'b1111;
         end
         default: ;
      endcase
   end

   // Lane select of the read word
   always_comb begin
      byte_sel = rdata_i[7:0];
      case (addr_lo_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: ;
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Sign/zero extension by load type
   always_comb begin
      ldata_o = rdata_i;
      case (funct3_i)
         F3_LB:  ldata_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU: ldata_o = {24'h0, byte_sel};
         F3_LH:  ldata_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU: ldata_o = {16'h0, half_sel};
         default: ldata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lam_unit.sv
// Load/store access manager: accepts a decoded memory command, runs one bus
// transaction with timeout, and writes extended load data back.
module lam_unit
   import lam_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lam_new,
   input  logic [8:0]  lam_control,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_sel,
   output logic [31:0] wb_data,
   output logic        err
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   lam_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [4:0]  rd_q;
   logic        st_q;

   logic        busy_q, mem_req_q, mem_we_q, wb_en_q, err_q;
   logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q;
   logic [3:0]  mem_wstrb_q;
   logic [4:0]  wb_sel_q;

   logic        idle, accept, bad_cmd, st_cur, rd_done;
   logic [2:0]  al_f3;
   logic [1:0]  al_lo;
   logic [31:0] al_wdata, al_ldata;
   logic [3:0]  al_wstrb;

   assign idle    = (state_q == ST_IDLE);
   assign accept  = idle && (lam_new || lam_control[8]);
   assign bad_cmd = !f3_legal(lam_control[8], lam_control[7:5]) ||
                    misaligned(lam_control[7:5], addr[1:0]);
   // Direction of the access being set up this cycle
   assign st_cur  = idle ? lam_control[8] : st_q;
   assign rd_done = (state_q == ST_BUS) && mem_ready && !st_q;

   // One aligner serves both phases: store steering at accept time, load
   // extraction from the captured command while on the bus.
   assign al_f3 = idle ? lam_control[7:5] : f3_q;
   assign al_lo = idle ? addr[1:0] : lo_q;

   lam_align u_align (
      .funct3_i  (al_f3),
      .addr_lo_i (al_lo),
      .sdata_i   (store_data),
      .rdata_i   (mem_rdata),
      .wdata_o   (al_wdata),
      .wstrb_o   (al_wstrb),
      .ldata_o   (al_ldata)
   );

   // Next-state and timeout counter; mem_ready has priority over timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d   = 8'd0;
               state_d = bad_cmd ? ST_ERR : ST_BUS;
            end
         end
         ST_BUS: begin
            if (mem_ready) begin
               state_d = st_q ? ST_IDLE : ST_WB;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TO_LIMIT) state_d = ST_ERR;
            end
         end
         ST_WB:   state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counter and registered outputs derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         busy_q    <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         err_q     <= 1'b0;
         wb_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= (state_d != ST_IDLE);
         mem_req_q <= (state_d == ST_BUS);
         mem_we_q  <= (state_d == ST_BUS) && st_cur;
         err_q     <= (state_d == ST_ERR);
         wb_en_q   <= rd_done && (rd_q != 5'd0);
      end
   end

   // Command capture and bus address/data setup at accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q        <= 3'd0;
         lo_q        <= 2'd0;
         rd_q        <= 5'd0;
         st_q        <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_wstrb_q <= 4'd0;
      end else if (accept) begin
         f3_q        <= lam_control[7:5];
         lo_q        <= addr[1:0];
         rd_q        <= lam_control[4:0];
         st_q        <= lam_control[8];
         mem_addr_q  <= {addr[31:2], 2'b00};
         mem_wdata_q <= lam_control[8] ? al_wdata : 32'd0;
         mem_wstrb_q <= lam_control[8] ? al_wstrb : 4'b0000;
      end
   end

   // Load result capture on the mem_ready cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_data_q <= 32'd0;
         wb_sel_q  <= 5'd0;
      end else if (rd_done) begin
         wb_data_q <= al_ldata;
         wb_sel_q  <= rd_q;
      end
   end

   assign busy      = busy_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign wb_en     = wb_en_q;
   assign wb_sel    = wb_sel_q;
   assign wb_data   = wb_data_q;
   assign err       = err_q;

endmodule

// File: tb/tb_lam_unit.sv
// Directed bench for lam_unit with hand-computed expectations.
module tb_lam_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lam_new = 1'b0;
   logic [8:0]  lam_control = 9'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        busy, mem_req, mem_we, wb_en, err;
   logic [31:0] mem_addr, mem_wdata, wb_data;
   logic [3:0]  mem_wstrb;
   logic [4:0]  wb_sel;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lam_unit #(.TIMEOUT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lam_new     (lam_new),
      .lam_control (lam_control),
      .addr        (addr),
      .store_data  (store_data),
      .busy        (busy),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .wb_en       (wb_en),
      .wb_sel      (wb_sel),
      .wb_data     (wb_data),
      .err         (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a command for one accept cycle; returns in cycle N+1
   task automatic issue(input logic nw, input logic st, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
      lam_new     = nw;
      lam_control = {st, f3, rd};
      addr        = a;
      store_data  = d;
      step();
      lam_new     = 1'b0;
      lam_control = 9'd0;
   endtask

   // Load with mem_ready on the first request cycle
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] rdat, input logic [31:0] exp);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      issue(1'b1, 1'b0, f3, rd, a, 32'd0);
      chk({tag, ".req"},   mem_req,   1);
      chk({tag, ".busy"},  busy,      1);
      chk({tag, ".addr"},  mem_addr,  wa);
      chk({tag, ".we"},    mem_we,    0);
      chk({tag, ".wstrb"}, mem_wstrb, 0);
      mem_ready = 1'b1;
      mem_rdata = rdat;
      step();
      mem_ready = 1'b0;
      chk({tag, ".wb_en"}, wb_en, (rd != 5'd0) ? 1 : 0);
      if (rd != 5'd0) begin
         chk({tag, ".wb_data"}, wb_data, exp);
         chk({tag, ".wb_sel"},  wb_sel,  rd);
      end
      chk({tag, ".req_lo"},  mem_req, 0);
      chk({tag, ".busy_wb"}, busy,    1);
      chk({tag, ".err"},     err,     0);
      step();
      chk({tag, ".busy_end"}, busy,  0);
      chk({tag, ".wb_off"},   wb_en, 0);
   endtask

   // Command that must fail at decode: err pulse, no bus, no writeback
   task automatic do_err(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
      issue(1'b1, st, f3, 5'd9, a, 32'hFFFF_FFFF);
      chk({tag, ".err"},  err,     1);
      chk({tag, ".busy"}, busy,    1);
      chk({tag, ".req"},  mem_req, 0);
      chk({tag, ".wb"},   wb_en,   0);
      step();
      chk({tag, ".err_lo"}, err,     0);
      chk({tag, ".idle"},   busy,    0);
      chk({tag, ".req2"},   mem_req, 0);
      chk({tag, ".wb2"},    wb_en,   0);
   endtask

   initial begin
      // Reset values
      #1;
      chk("rst.busy",  busy,      0);
      chk("rst.req",   mem_req,   0);
      chk("rst.we",    mem_we,    0);
      chk("rst.wb_en", wb_en,     0);
      chk("rst.err",   err,       0);
      chk("rst.addr",  mem_addr,  0);
      chk("rst.wdata", mem_wdata, 0);
      chk("rst.wstrb", mem_wstrb, 0);
      chk("rst.sel",   wb_sel,    0);
      chk("rst.data",  wb_data,   0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Loads: word, signed/unsigned byte and half
      do_load("lw",   3'b010, 5'd5, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      do_load("lb",   3'b000, 5'd1, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
      do_load("lbu",  3'b100, 5'd2, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
      do_load("lb1",  3'b000, 5'd4, 32'h0000_0101, 32'h0000_7F00, 32'h0000_007F);
      do_load("lh",   3'b001, 5'd6, 32'h0000_0102, 32'h8001_1111, 32'hFFFF_8001);
      do_load("lhu",  3'b101, 5'd8, 32'h0000_0100, 32'h1234_F00F, 32'h0000_F00F);
      do_load("lw0",  3'b010, 5'd0, 32'h0000_0010, 32'h5555_AAAA, 32'h0);

      // SH with ready on the 4th request cycle (also the timeout-count boundary)
      issue(1'b1, 1'b1, 3'b001, 5'd3, 32'h0000_0206, 32'h1234_ABCD);
      for (int i = 0; i < 4; i++) begin
         chk("sh.req",   mem_req,   1);
         chk("sh.we",    mem_we,    1);
         chk("sh.addr",  mem_addr,  32'h0000_0204);
         chk("sh.wdata", mem_wdata, 32'hABCD_ABCD);
         chk("sh.wstrb", mem_wstrb, 4'b1100);
         chk("sh.wb",    wb_en,     0);
         if (i == 3) mem_ready = 1'b1;
         step();
      end
      mem_ready = 1'b0;
      chk("sh.req_lo", mem_req, 0);
      chk("sh.busy",   busy,    0);
      chk("sh.wb_end", wb_en,   0);
      chk("sh.err",    err,     0);

      // SW full word
      issue(1'b1, 1'b1, 3'b010, 5'd3, 32'h0000_0300, 32'hCAFE_F00D);
      chk("sw.wdata", mem_wdata, 32'hCAFE_F00D);
      chk("sw.wstrb", mem_wstrb, 4'b1111);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("sw.done", busy, 0);

      // Decode errors
      do_err("lw_mis",  1'b0, 3'b010, 32'h0000_0102);
      do_err("ld_ill",  1'b0, 3'b011, 32'h0000_0100);
      do_err("lh_mis",  1'b0, 3'b101, 32'h0000_0101);
      do_err("st_ill",  1'b1, 3'b100, 32'h0000_0100);

      // Timeout: 4 request cycles, then err pulse
      issue(1'b1, 1'b0, 3'b010, 5'd3, 32'h0000_0040, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("to.req", mem_req, 1);
         chk("to.err", err,     0);
         step();
      end
      chk("to.req_lo", mem_req, 0);
      chk("to.err_hi", err,     1);
      chk("to.busy",   busy,    1);
      chk("to.wb",     wb_en,   0);
      step();
      chk("to.idle",   busy, 0);
      chk("to.err_lo", err,  0);

      // Follow-up SB, accepted via is_store alone
      issue(1'b0, 1'b1, 3'b000, 5'd7, 32'h0000_0041, 32'h0000_0055);
      chk("sb.req",   mem_req,   1);
      chk("sb.addr",  mem_addr,  32'h0000_0040);
      chk("sb.wdata", mem_wdata, 32'h5555_5555);
      chk("sb.wstrb", mem_wstrb, 4'b0010);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("sb.done", mem_req, 0);
      chk("sb.err",  err,     0);
      chk("sb.busy", busy,    0);

      // Reset in the middle of a load
      issue(1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0300, 32'd0);
      chk("rm.req", mem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("rm.req_lo", mem_req,  0);
      chk("rm.busy",   busy,     0);
      chk("rm.addr",   mem_addr, 0);
      mem_ready = 1'b1;
      mem_rdata = 32'h1111_2222;
      step();
      mem_ready = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rm.wb",   wb_en, 0);
         chk("rm.idle", busy,  0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lam_unit.md
# lam_unit

Load/store access manager (LAM) sitting between the instruction decoder and the data-memory bus. It accepts the decoder's `lam_control`/`lam_new` command together with the ALU-computed effective address and the store operand. It then runs one memory transaction with a ready handshake, with byte-lane steering and load sign/zero extension, and writes loaded data back to the register file. It raises `busy` so the core stalls while an access is in flight, and flags misaligned, illegal or timed-out accesses.

## Interface
- `TIMEOUT`, 255: max cycles `mem_req` is held without `mem_ready` before abort (1..255).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `lam_new` in 1: load command strobe from the decoder.
- `lam_control` in 9: {`is_store`[8], `funct3`[7:5], `reg`[4:0]}; `reg` = rd for loads, rs2 index for stores (informational).
- `addr` in 32: effective address (ALU result), valid in the accept cycle.
- `store_data` in 32: rs2 value, valid in the accept cycle.
- `busy` out 1: transaction in flight; core must hold decoder inputs stable.
- `mem_req` out 1: bus request, held until `mem_ready`.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address {addr[31:2], 2'b00}.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte enables (0000 on reads).
- `mem_ready` in 1: responder accept/data-valid.
- `mem_rdata` in 32: read word, valid when `mem_ready`=1.
- `wb_en` out 1: one-cycle register-file write strobe.
- `wb_sel` out 5: destination register.
- `wb_data` out 32: extended load result.
- `err` out 1: one-cycle pulse on misaligned, illegal `funct3` or timeout.

## Operation
- Accept: in IDLE, when `lam_new`=1 or `lam_control[8]`=1. Register addr, data, funct3, reg, is_store. Inputs are ignored while not in IDLE.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Anything else is illegal.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- FSM states:
  - IDLE: legal accept → BUS; misaligned or illegal accept → ERR.
  - BUS: `mem_ready` & load → WB; `mem_ready` & store → IDLE; timeout → ERR.
  - WB → IDLE.
  - ERR → IDLE.
- Store steering:
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wdata=d, wstrb=1111.
- Load extraction: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- rdata is captured on the `mem_ready` cycle.
- Load with rd=0: the bus access is performed, but `wb_en` stays 0.
- Timeout counter: cleared on entry to BUS, increments each BUS cycle without `mem_ready`. When it reaches TIMEOUT, `mem_req` is dropped and the FSM goes to ERR. If `mem_ready` arrives on the same cycle the counter hits TIMEOUT, `mem_ready` wins.
- No bus access is made for ERR paths; `wb_en` is never asserted with `err`.

## Timing
- Reset: state IDLE. `busy`, `mem_req`, `mem_we`, `wb_en` and `err` are 0. `mem_addr`, `mem_wdata`, `mem_wstrb`, `wb_sel`, `wb_data` and the counter are 0. Reset mid-transaction aborts immediately: `mem_req` drops asynchronously and no writeback occurs.
- All outputs are registered.
- Load accepted at cycle N:
  - `mem_req`/`busy` are high from N+1.
  - `mem_ready` sampled high at cycle M ≥ N+1 → `wb_en` at M+1.
  - `busy` is low from M+2, and the next accept is possible at M+2.
  - Minimum latency is 2 cycles to writeback.
- Store: `mem_ready` at M → `mem_req`/`busy` low at M+1.
- Error: accept at N → `err`=1 and `busy`=1 at N+1, IDLE at N+2.
- Bus signals stay stable while `mem_req`=1 and `mem_ready`=0.

## Structure
- Package `lam_pkg`:
  - funct3 constants (LB…LHU, SB/SH/SW).
  - `LAM_STORE`=1, `LAM_LOAD`=0.
  - FSM state encoding (IDLE, BUS, WB, ERR).
- Sub-module `lam_align`: combinational store lane steering and load extract/extend. It is instantiated once; the FSM, counter and registers live in `lam_unit`.

## Test plan
- LW at 0x100, `mem_ready` on the first req cycle, rdata=0xDEADBEEF → `mem_addr`=0x100, `wb_en` at N+2 with `wb_data`=0xDEADBEEF and the commanded rd.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF_0000 → `wb_data`=0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x206 with store_data=0x1234ABCD, `mem_ready` delayed 3 cycles → wdata=0xABCDABCD, wstrb=1100, `mem_addr`=0x204 held stable 4 cycles, no `wb_en`.
- LW at 0x102 and an illegal load funct3=011 → `err` pulse at N+1, `mem_req` never asserted, no `wb_en`.
- TIMEOUT=4 with `mem_ready` never asserted → `mem_req` high 4 cycles then `err` pulse, IDLE; a follow-up SB succeeds.
- `rst_n` low during BUS of a load → `mem_req`/`busy` drop immediately, no `wb_en` after release; LW to rd=0 → bus read occurs, `wb_en`=0.
